// File: rtl/mod113_pkg.sv
// Shared constants and types for the mod-113 reduction path.
package mod113_pkg;

  localparam int MODULUS = 113;
  localparam int RW      = 7;

  typedef logic [RW-1:0] residue_t;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mod113_add.sv
// Combinational modular adder: (a + b) mod MODULUS, with a already reduced
// and b any RW-bit value.
module mod113_add #(
  parameter int MODULUS = mod113_pkg::MODULUS,
  parameter int RW      = mod113_pkg::RW
) (
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] sum
);

  localparam logic [RW-1:0] MOD_N = RW'(MODULUS);
  localparam logic [RW:0]   MOD_W = (RW+1)'(MODULUS);

  logic [RW-1:0] b_red;
  logic [RW:0]   s_raw;
  logic [RW:0]   s_red;

  // A single subtract suffices on both steps because 2*MODULUS > 2^RW.
  always_comb begin
    b_red = (b >= MOD_N) ? (b - MOD_N) : b;
    s_raw = {1'b0, a} + {1'b0, b_red};
    s_red = (s_raw >= MOD_W) ? (s_raw - MOD_W) : s_raw;
    sum   = s_red[RW-1:0];
  end

endmodule

// File: rtl/mod113_residue_accum.sv
// Frame accumulator: sums partial residues mod MODULUS per in_last-delimited
// frame and presents one result through a single-entry valid/ready buffer.
module mod113_residue_accum #(
  parameter int MODULUS   = mod113_pkg::MODULUS,
  parameter int RW        = mod113_pkg::RW,
  parameter int MAX_TERMS = 16,
  parameter int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic [CW-1:0] out_terms,
  output logic          out_err
);

  import mod113_pkg::*;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

  state_e        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_terms_q, out_terms_d;
  logic          out_err_q, out_err_d;

  logic [RW-1:0] sum;
  logic [CW-1:0] cnt_inc;
  logic          ovf_inc;
  logic          accept;

  mod113_add #(
    .MODULUS (MODULUS),
    .RW      (RW)
  ) u_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (sum)
  );

  always_comb begin
    cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : (cnt_q + CW'(1));
    ovf_inc = ovf_q | (cnt_q == MAX_CNT);
  end

  // acc/cnt/ovf are already cleared whenever HOLD is entered, so a beat taken
  // while the result drains starts a fresh frame on the same datapath.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_terms_d = out_terms_q;
    out_err_d   = out_err_q;
    in_ready    = 1'b1;
    out_valid   = 1'b0;

    case (state_q)
      ACC: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase

    accept = in_valid & in_ready;

    if (accept) begin
      if (in_last) begin
        out_data_d  = sum;
        out_terms_d = cnt_inc;
        out_err_d   = ovf_inc;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = HOLD;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_inc;
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_terms_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_terms_q <= out_terms_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_terms = out_terms_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod113_residue_accum.sv
// Bench for mod113_residue_accum: fixed frame table, hand-written handshake
// and reset sequences, then random frames against a sum-mod-113 model.
module tb_mod113_residue_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic [4:0] out_terms;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  mod113_residue_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_terms (out_terms),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int beats[17];
    int exp_data;
    int exp_terms;
    int exp_err;
  } vec_t;

  typedef struct {
    logic [6:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    int data;
    int terms;
    int err;
  } res_t;

  vec_t  vecs[5];
  beat_t beat_q[$];
  res_t  exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit l);
    in_valid = 1'b1;
    in_data  = 7'(d);
    in_last  = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input int v, input int d, input int t, input int e);
    chk({name, ".valid"}, int'(out_valid), v);
    chk({name, ".data"},  int'(out_data),  d);
    chk({name, ".terms"}, int'(out_terms), t);
    chk({name, ".err"},   int'(out_err),   e);
    $display("txn %s: valid=%0d data=%0d terms=%0d err=%0d", name, out_valid, out_data, out_terms, out_err);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    vecs[0].len = 2; vecs[0].beats[0] = 100; vecs[0].beats[1] = 50;
    vecs[0].exp_data = 37; vecs[0].exp_terms = 2; vecs[0].exp_err = 0;
    vecs[1].len = 3; vecs[1].beats[0] = 112; vecs[1].beats[1] = 112; vecs[1].beats[2] = 112;
    vecs[1].exp_data = 110; vecs[1].exp_terms = 3; vecs[1].exp_err = 0;
    vecs[2].len = 1; vecs[2].beats[0] = 127;
    vecs[2].exp_data = 14; vecs[2].exp_terms = 1; vecs[2].exp_err = 0;
    vecs[3].len = 17;
    for (int i = 0; i < 17; i++) vecs[3].beats[i] = 1;
    vecs[3].exp_data = 17; vecs[3].exp_terms = 16; vecs[3].exp_err = 1;
    vecs[4].len = 1; vecs[4].beats[0] = 3;
    vecs[4].exp_data = 3; vecs[4].exp_terms = 1; vecs[4].exp_err = 0;

    repeat (3) tick();
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.in_ready", int'(in_ready), 1);
    rst = 1'b0;
    tick();

    // Table-driven frames, out_ready held high.
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].len; b++) send(vecs[v].beats[b], b == vecs[v].len - 1);
      chk_out($sformatf("vec%0d", v), 1, vecs[v].exp_data, vecs[v].exp_terms, vecs[v].exp_err);
      tick();
      chk($sformatf("vec%0d.drain", v), int'(out_valid), 0);
    end

    // Backpressure: result must stay put while out_ready is low.
    out_ready = 1'b0;
    send(5, 1'b0);
    send(7, 1'b1);
    in_valid = 1'b1; in_data = 7'd9; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_out($sformatf("bp_hold%0d", c), 1, 12, 2, 0);
      chk($sformatf("bp_hold%0d.in_ready", c), int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", int'(in_ready), 1);
    chk_out("bp_release", 1, 12, 2, 0);
    tick();
    in_valid = 1'b0;
    chk_out("bp_next", 1, 9, 1, 0);
    tick();
    chk("bp_drain.valid", int'(out_valid), 0);

    // Back-to-back single-beat frames.
    for (int k = 1; k <= 3; k++) begin
      send(k, 1'b1);
      chk_out($sformatf("b2b%0d", k), 1, k, 1, 0);
    end
    tick();
    chk("b2b_drain.valid", int'(out_valid), 0);

    // Asynchronous reset drops a pending result immediately.
    out_ready = 1'b0;
    send(20, 1'b1);
    chk_out("pend", 1, 20, 1, 0);
    rst = 1'b1;
    #1;
    chk_out("pend_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset mid-frame discards the partial sum.
    send(50, 1'b0);
    send(60, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    send(4, 1'b1);
    chk_out("post_rst", 1, 4, 1, 0);
    tick();

    // Random frames checked against a plain sum-mod-113 model.
    for (int f = 0; f < 40; f++) begin
      int n;
      int s;
      n = int'($urandom_range(1, 20));
      s = 0;
      for (int b = 0; b < n; b++) begin
        beat_t bt;
        bt.d = 7'($urandom_range(0, 127));
        bt.l = (b == n - 1);
        s += int'(bt.d);
        beat_q.push_back(bt);
      end
      exp_q.push_back('{data: s % 113, terms: (n > 16) ? 16 : n, err: (n > 16) ? 1 : 0});
    end

    begin
      bit consumed;
      int budget;
      consumed = 1'b0;
      budget = 0;
      while ((beat_q.size() > 0 || exp_q.size() > 0 || in_valid) && budget < 20000) begin
        budget++;
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid) begin
          if (beat_q.size() > 0 && $urandom_range(0, 4) != 0) begin
            beat_t bt;
            bt = beat_q.pop_front();
            in_valid = 1'b1;
            in_data  = bt.d;
            in_last  = bt.l;
          end else begin
            in_data = 7'($urandom);
            in_last = 1'($urandom);
          end
        end
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rnd_extra: got result %0d, expected none", out_data);
          end else begin
            res_t r;
            r = exp_q.pop_front();
            chk("rnd.data",  int'(out_data),  r.data);
            chk("rnd.terms", int'(out_terms), r.terms);
            chk("rnd.err",   int'(out_err),   r.err);
            $display("txn rnd: data=%0d terms=%0d err=%0d", out_data, out_terms, out_err);
          end
        end
        consumed = in_valid && in_ready;
        tick();
        if (consumed) in_valid = 1'b0;
      end
      if (beat_q.size() != 0 || exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout: got %0d results outstanding, expected 0", exp_q.size());
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod113_residue_accum.md
Name: mod113_residue_accum

Overview:
- Sequential accumulator stage directly downstream of the 6-input/7-output residue LUTs in the mod-113 reduction path.
- Consumes a stream of 7-bit partial residues, one per LUT chunk, and sums them modulo 113 across a frame delimited by in_last.
- Emits one fully reduced 7-bit residue per frame on a valid/ready output.
- Provides single-entry output buffering with backpressure.

Parameters:
- MODULUS, 113, modulus; must satisfy 2^(RW-1) < MODULUS < 2^RW.
- RW, 7, residue width of input and output.
- MAX_TERMS, 16, maximum legal beats per frame.
- CW, $clog2(MAX_TERMS+1), term-counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  partial residue valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  RW  partial residue, 0..2^RW-1.
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  RW  frame residue, 0..MODULUS-1.
- out_terms  out  CW  beats in frame, saturating at MAX_TERMS.
- out_err  out  1  frame exceeded MAX_TERMS beats.

Behaviour:
- One clock domain. Asynchronous active-high reset.
- Reset values:
  - state=ACC, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_data=0, out_terms=0, out_err=0.
- Input accept: a beat is accepted when in_valid & in_ready.
- Input pre-reduction: d' = (in_data >= MODULUS) ? in_data-MODULUS : in_data. With RW=7, 113..127 map to 0..14.
- Modular add: s = acc + d', computed in RW+1 bits. sum = (s >= MODULUS) ? s-MODULUS : s. Result is always < MODULUS.
- States:
  - ACC:
    - in_ready=1, out_valid=0.
    - Accepted beat without in_last: acc<=sum; cnt<=min(cnt+1, MAX_TERMS); ovf<=ovf | (cnt==MAX_TERMS).
    - Accepted beat with in_last:
      - out_data<=sum.
      - out_terms<=min(cnt+1, MAX_TERMS).
      - out_err<=ovf | (cnt==MAX_TERMS).
      - acc<=0, cnt<=0, ovf<=0.
      - Go to HOLD.
  - HOLD:
    - out_valid=1.
    - in_ready = out_ready, a combinational pass-through.
    - out_ready=1 with no accepted beat: go to ACC.
    - out_ready=1 with an accepted beat: the result is consumed and the beat is processed exactly as in ACC in the same cycle, starting from acc=0.
      - Beat has in_last: new result loaded, stay in HOLD. This gives 1 frame/cycle throughput for single-beat frames.
      - Beat without in_last: go to ACC.
    - out_ready=0: out_data, out_terms and out_err hold stable, and in_ready=0.
- Latency: out_valid asserts on the cycle after the in_last beat is accepted.
- Single-beat frame: the result is d'.
- Empty frames do not exist; every frame has at least one beat.
- Overflow: beats beyond MAX_TERMS are still accumulated, so the result stays arithmetically correct. out_terms saturates and out_err=1 for that frame only.
- Reset mid-frame: the partial accumulation is discarded and any pending result is dropped. out_valid deasserts asynchronously.
- in_data and in_last are ignored when in_valid=0.

Decomposition:
- Shared package mod113_pkg:
  - Constants MODULUS=113 and RW=7.
  - Typedef residue_t (logic [RW-1:0]).
  - Typedef state_e {ACC, HOLD}.
- Sub-module mod113_add, purely combinational:
  - Inputs: residue a (< MODULUS) and raw b (any RW-bit value).
  - Output: (a + b) mod MODULUS.
  - Contains the pre-reduction and the conditional subtract, and is reused by later reduction stages.
- Top module: FSM, counter and output register.

Test Plan:
- Frame [100, 50(last)], out_ready=1 → one cycle after the last beat: out_valid=1, out_data=37, out_terms=2, out_err=0.
- Frame [112, 112, 112(last)] → out_data=110. Single beat [127(last)] → out_data=14 (pre-reduction check).
- Backpressure: complete frame [5, 7(last)], hold out_ready=0 for 5 cycles → out_data=12 stable, in_ready=0 throughout. Raise out_ready with a concurrent [9(last)] beat → 12 handshakes, then next cycle out_data=9.
- Back-to-back single-beat frames 1, 2, 3 with out_ready=1 every cycle → results 1, 2, 3 on consecutive cycles, no bubbles.
- Overflow: 17 beats of value 1 (last on the 17th), MAX_TERMS=16 → out_data=17, out_terms=16, out_err=1. The following frame [3(last)] → out_err=0, out_terms=1.
- Reset: assert rst after 2 beats [50, 60] of a frame → outputs zero at once. After release, frame [4(last)] → out_data=4, with no carry-over.
